// File: rtl/freq_gate_ctrl_if.sv
// freq_gate_ctrl_if: control/status bundle between the UI/range logic, the measured signal and the gate sequencer.
interface freq_gate_ctrl_if;
    logic       start;
    logic       continuous;
    logic [1:0] range;
    logic       sig_in;
    logic       gate;
    logic       busy;
    logic       done;
    logic       no_signal;
    logic [1:0] range_q;

    modport master (
        output start, continuous, range, sig_in,
        input  gate, busy, done, no_signal, range_q
    );

    modport slave (
        input  start, continuous, range, sig_in,
        output gate, busy, done, no_signal, range_q
    );
endinterface

// File: rtl/freq_gate_ctrl.sv
// freq_gate_ctrl: frequency-counter gate sequencer with selectable gate length, post-gate settle and no-signal detection.
module freq_gate_ctrl #(
    parameter int CLK_HZ         = 50_000_000,
    parameter int TIMEOUT_CYCLES = CLK_HZ,
    parameter int SETTLE_CYCLES  = 4
) (
    input logic             clk,
    input logic             rst,
    freq_gate_ctrl_if.slave bus
);
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] GATE   = 2'd1;
    localparam logic [1:0] SETTLE = 2'd2;
    localparam logic [1:0] DONE   = 2'd3;

    // Timer loads are length-1 so the timer reaches zero on the last cycle of the window.
    localparam logic [31:0] GL0     = 32'(CLK_HZ / 2 - 1);
    localparam logic [31:0] GL1     = 32'(CLK_HZ / 20 - 1);
    localparam logic [31:0] GL2     = 32'(CLK_HZ / 200 - 1);
    localparam logic [31:0] GL3     = 32'(CLK_HZ / 2000 - 1);
    localparam logic [31:0] TO_LOAD = 32'(TIMEOUT_CYCLES - 1);
    localparam logic [31:0] ST_LOAD = 32'(SETTLE_CYCLES - 1);

    logic [1:0]  state, nxt;
    logic [31:0] timer, timer_nxt, gate_load;
    logic        act, act_nxt, seen, seen_nxt, ns_nxt;
    logic        s1, s2, s3, sig_rise;

    assign sig_rise  = s2 & ~s3;
    assign gate_load = bus.range == 2'd0 ? GL0 :
                       bus.range == 2'd1 ? GL1 :
                       bus.range == 2'd2 ? GL2 : GL3;

    always_comb begin
        nxt       = state;
        timer_nxt = timer;
        act_nxt   = act;
        seen_nxt  = seen;
        ns_nxt    = bus.no_signal;
        case (state)
            IDLE: if (bus.start || bus.continuous) begin
                nxt       = GATE;
                timer_nxt = gate_load;
                act_nxt   = 1'b0;
            end
            GATE: begin
                act_nxt = act | sig_rise;
                if (timer == '0) begin
                    nxt       = act_nxt ? SETTLE : DONE;
                    ns_nxt    = act_nxt ? bus.no_signal : 1'b1;
                    timer_nxt = TO_LOAD;
                    seen_nxt  = 1'b0;
                end else begin
                    timer_nxt = timer - 32'd1;
                end
            end
            SETTLE: if (seen) begin
                // Counter has latched; wait out synchronizer and latch margin.
                if (timer == '0) begin
                    nxt    = DONE;
                    ns_nxt = 1'b0;
                end else begin
                    timer_nxt = timer - 32'd1;
                end
            end else if (sig_rise) begin
                seen_nxt  = 1'b1;
                timer_nxt = ST_LOAD;
            end else if (timer == '0) begin
                nxt    = DONE;
                ns_nxt = 1'b1;
            end else begin
                timer_nxt = timer - 32'd1;
            end
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= IDLE;
            timer         <= '0;
            act           <= 1'b0;
            seen          <= 1'b0;
            s1            <= 1'b0;
            s2            <= 1'b0;
            s3            <= 1'b0;
            bus.gate      <= 1'b0;
            bus.busy      <= 1'b0;
            bus.done      <= 1'b0;
            bus.no_signal <= 1'b0;
            bus.range_q   <= 2'd0;
        end else begin
            state         <= nxt;
            timer         <= timer_nxt;
            act           <= act_nxt;
            seen          <= seen_nxt;
            s1            <= bus.sig_in;
            s2            <= s1;
            s3            <= s2;
            bus.gate      <= nxt == GATE;
            bus.busy      <= nxt != IDLE;
            bus.done      <= nxt == DONE;
            bus.no_signal <= ns_nxt;
            if (state == IDLE && nxt == GATE)
                bus.range_q <= bus.range;
        end
    end
endmodule

// File: doc/freq_gate_ctrl.md
# freq_gate_ctrl

Measurement sequencer for the frequency counter. Generates the counter's gate (enable) window from the system clock with selectable length, waits for the counter, which is clocked by the measured signal, to capture its result, then reports completion. Supports single-shot and continuous modes and detects absent input signal. Sits between the UI/range logic and the counter's `enable` input.

## Interface
**Parameters**
- `CLK_HZ`, 50_000_000: system clock frequency.
- `TIMEOUT_CYCLES`, CLK_HZ: maximum post-gate wait for a measured-signal edge.
- `SETTLE_CYCLES`, 4: margin after the post-gate edge is seen, covering synchronizer latency and counter latch time.

**Ports**
- `clk`, in, 1: system clock.
- `rst`, in, 1: asynchronous, active-low reset.
- `start`, in, 1: single-shot request, sampled in IDLE.
- `continuous`, in, 1: when 1, a new measurement starts automatically from IDLE.
- `range`, in, 2: gate length select, sampled at measurement start.
- `sig_in`, in, 1: measured signal, asynchronous to `clk`.
- `gate`, out, 1: counter enable; 1 only in GATE state.
- `busy`, out, 1: 1 in every state except IDLE.
- `done`, out, 1: one-cycle pulse at the end of each measurement.
- `no_signal`, out, 1: validity flag for the last measurement. Updated with `done`. 1 means the counter result is stale or invalid.
- `range_q`, out, 2: range used by the last or current measurement.

## Operation
**Gate length** `GATE_LEN(r)`:
- r=0: CLK_HZ/2
- r=1: CLK_HZ/20
- r=2: CLK_HZ/200
- r=3: CLK_HZ/2000

Each step is ×10, so the display shifts its decimal point by `range_q`. At r=0 the counter's ×2 gives Hz directly.

**Gate timer**
- 32-bit down-counter; integer division is done at elaboration.

**Input synchronization**
- `sig_in` passes through a 2-FF synchronizer plus an edge register.
- `sig_rise` = synced & ~prev.

**States**
- **IDLE**
  - `gate`=0, `busy`=0.
  - If `start`=1 or `continuous`=1: latch `range`→`range_q`, load timer with GATE_LEN−1, clear the activity flag, go to GATE.
- **GATE**
  - `gate`=1.
  - Any `sig_rise` sets the activity flag.
  - Timer decrements each cycle. At timer=0, go to SETTLE if activity=1, otherwise go to DONE with `no_signal`←1.
- **SETTLE**
  - `gate`=0.
  - Wait for the first `sig_rise` (the counter latches on this edge), then count SETTLE_CYCLES, then go to DONE with `no_signal`←0.
  - If TIMEOUT_CYCLES elapse with no `sig_rise`, go to DONE with `no_signal`←1.
  - Edges that occur in the first cycles of SETTLE but were launched during GATE still count. This is acceptable because the counter has at least one edge pending.
- **DONE**
  - `done`=1 for exactly one cycle, then go to IDLE.

**Boundary rules**
- `start` while `busy` is ignored; requests are not queued.
- `range` changes after the start cycle are ignored until the next IDLE.
- `continuous` deasserted mid-measurement: the current measurement completes with `done`, then the block stays in IDLE.
- `start` and `continuous` both 1 in IDLE: a single start; behaviour is identical.
- `rst` low at any time:
  - State→IDLE immediately.
  - `gate`, `busy`, `done`, `no_signal`=0; `range_q`=0; timers cleared.
  - No `done` is issued for the aborted measurement.

## Timing
**Reset values**
- `gate`=0, `busy`=0, `done`=0, `no_signal`=0, `range_q`=0.

**Measurement sequence**
- Start sampled at cycle N.
- `gate` and `busy` rise at N+1; `range_q` is valid at N+1.
- `gate` is high for exactly GATE_LEN cycles (N+1..N+GATE_LEN).
- No activity: `done` at N+GATE_LEN+1.
- With activity: `done` arrives SETTLE_CYCLES+1 cycles after the cycle in which `sig_rise` is seen in SETTLE.
- `busy` falls the cycle after `done`.

**Continuous mode**
- IDLE lasts one cycle.
- Gate-low gap = SETTLE duration + 2 cycles.

**Outputs**
- All outputs are registered.
- `sig_in`→`sig_rise` latency is 3 cycles.

## Test plan
Use `CLK_HZ`=20000 (gate lengths 10000/1000/100/10), `TIMEOUT_CYCLES`=20000, `SETTLE_CYCLES`=4.
1. `range`=3, `sig_in` toggling every 3 cycles, `start` pulse at cycle 0 → `gate` high for cycles 1–10 exactly, `range_q`=3, `done` once with `no_signal`=0, `busy` low the cycle after `done`.
2. `range`=2, `sig_in` held 0, `start` → `gate` high for 100 cycles, `done` at cycle 101, `no_signal`=1.
3. `range`=3, `sig_in` toggling only during the gate and held 0 after → `done` 20000 cycles after `gate` falls, `no_signal`=1.
4. `continuous`=1, `range`=3, `sig_in` toggling every 3 cycles → repeated 10-cycle gates; clear `continuous` mid-gate → that measurement ends with `done`, then no further `gate`.
5. `start` re-pulsed during GATE and `range` changed from 3 to 0 mid-gate → ignored; `gate` still 10 cycles, `range_q`=3.
6. `rst` low during GATE at cycle 5 → `gate`=0 and `busy`=0 immediately, no `done`; after `rst` is released, block idle until the next `start`.
